fpga_iser10_align: RTL

- Receive-side counterpart of the 10:1 TMDS/HDMI serializer path.
- Takes raw 10-bit parallel words from a 1:10 deserializer at arbitrary bit phase and finds the word boundary by hunting for TMDS control tokens. Alignment is done with an internal barrel shift, not the primitive bitslip.
- Delivers aligned words plus lock status to the downstream TMDS decoder.
- Runs entirely in the parallel-clock domain.

---
 rtl/fpga_iser10_align.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fpga_iser10_align.sv
// TMDS receive word aligner: finds the 10-bit word boundary of a deserialized
// stream by hunting for control tokens through a 20-bit barrel-shift window.
module fpga_iser10_align #(
  parameter int unsigned SEARCH_WORDS = 1024,
  parameter int unsigned LOCK_TOKENS  = 8,
  parameter int unsigned LOSS_WORDS   = 65536
) (
  input  logic       clk_par,
  input  logic       rst,
  input  logic [9:0] d_in,
  input  logic       d_vld,
  output logic [9:0] q,
  output logic       q_vld,
  output logic       q_token,
  output logic       locked,
  output logic [3:0] offset,
  output logic       lock_lost
);

  localparam int unsigned BW = $clog2(SEARCH_WORDS + 1);
  localparam int unsigned HW = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned IW = $clog2(LOSS_WORDS + 1);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic [3:0]    offset_q,   offset_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [HW-1:0] hit_cnt_q,  hit_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [9:0]    d_prev_q,   d_prev_d;
  logic [9:0]    word_q,     word_d;
  logic          vld_q,      vld_d;
  logic          tok_q,      tok_d;
  logic          locked_q,   locked_d;
  logic          lost_q,     lost_d;

  logic [19:0]   win_c;
  logic [9:0]    cand_c;
  logic          tok_c;
  logic [3:0]    off_nxt_c;
  logic [BW-1:0] beat_sat_c;
  logic [HW-1:0] hit_inc_c;
  logic [IW-1:0] idle_inc_c;

  // Previous word holds the earlier serial bits, so offset 0 selects it intact.
  assign win_c  = {d_in, d_prev_q};
  assign cand_c = win_c[{1'b0, offset_q} +: 10];
  assign tok_c  = (cand_c == 10'h354) || (cand_c == 10'h0AB) ||
                  (cand_c == 10'h154) || (cand_c == 10'h2AB);

  assign off_nxt_c  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  assign beat_sat_c = (beat_cnt_q == BW'(SEARCH_WORDS)) ? beat_cnt_q
                                                        : beat_cnt_q + BW'(1);
  assign hit_inc_c  = hit_cnt_q + HW'(1);
  assign idle_inc_c = idle_cnt_q + IW'(1);

  // Next-state and output logic; everything only moves on valid beats.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    beat_cnt_d = beat_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    d_prev_d   = d_prev_q;
    word_d     = word_q;
    tok_d      = tok_q;
    vld_d      = 1'b0;
    lost_d     = 1'b0;
    if (d_vld) begin
      d_prev_d = d_in;
      word_d   = cand_c;
      tok_d    = tok_c;
      vld_d    = 1'b1;
      case (state_q)
        ST_SEARCH: begin
          beat_cnt_d = beat_sat_c;
          if (tok_c) begin
            state_d   = ST_CONFIRM;
            hit_cnt_d = HW'(1);
          end else if (beat_sat_c == BW'(SEARCH_WORDS)) begin
            offset_d   = off_nxt_c;
            beat_cnt_d = '0;
          end
        end
        ST_CONFIRM: begin
          beat_cnt_d = beat_sat_c;
          if (tok_c) hit_cnt_d = hit_inc_c;
          // Lock takes priority over a timeout on the same beat.
          if (tok_c && (hit_cnt_q >= HW'(LOCK_TOKENS - 1))) begin
            state_d    = ST_LOCKED;
            idle_cnt_d = '0;
          end else if (beat_sat_c == BW'(SEARCH_WORDS)) begin
            state_d    = ST_SEARCH;
            offset_d   = off_nxt_c;
            beat_cnt_d = '0;
            hit_cnt_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (tok_c) begin
            idle_cnt_d = '0;
          end else if (idle_inc_c == IW'(LOSS_WORDS)) begin
            state_d    = ST_SEARCH;
            lost_d     = 1'b1;
            beat_cnt_d = '0;
            hit_cnt_d  = '0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_inc_c;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_par) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      offset_q   <= '0;
      beat_cnt_q <= '0;
      hit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      d_prev_q   <= '0;
      word_q     <= '0;
      vld_q      <= 1'b0;
      tok_q      <= 1'b0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      beat_cnt_q <= beat_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      d_prev_q   <= d_prev_d;
      word_q     <= word_d;
      vld_q      <= vld_d;
      tok_q      <= tok_d;
      locked_q   <= locked_d;
      lost_q     <= lost_d;
    end
  end

  assign q         = word_q;
  assign q_vld     = vld_q;
  assign q_token   = tok_q;
  assign locked    = locked_q;
  assign offset    = offset_q;
  assign lock_lost = lost_q;

endmodule
